// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_tree_pipe.sv
// Pipelined wide-NOR reduction built from a tree of 4-input OR groups.
// Stage 1..LEVELS-1 are OR-group registers; the last OR group feeds the
// result stage directly, so the latency is LEVELS rising edges (with EN=1).
// The result stage supports plain/sticky NOR, a clear, and a saturating
// count of samples whose OR was 1.
module gf180mcu_fd_sc_mcu7t5v0__nor_tree_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             VLD_I,
  input  logic [WIDTH-1:0] A,
  input  logic             MODE,
  input  logic             CLR,
  output logic             ZN,
  output logic             VLD_O,
  output logic [CNT_W-1:0] CNT
);

  // ceil(log4(w)) with a floor of 1; WIDTH never exceeds 4^4.
  function automatic int calc_levels(input int w);
    int lv;
    int cap;
    lv  = 1;
    cap = 4;
    for (int i = 0; i < 4; i++) begin
      if (cap < w) begin
        cap = cap * 4;
        lv  = lv + 1;
      end else begin
        cap = cap;
      end
    end
    return lv;
  endfunction

  localparam int LEVELS = calc_levels(WIDTH);
  localparam int PAD    = 1 << (2 * LEVELS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  // ORs every aligned group of 4 bits into the low PAD/4 bits; the rest are 0.
  function automatic logic [PAD-1:0] group_or(input logic [PAD-1:0] x);
    logic [PAD-1:0] y;
    y = '0;
    for (int g = 0; g < PAD / 4; g++) begin
      y[g] = |x[4*g +: 4];
    end
    return y;
  endfunction

  logic [PAD-1:0]   a_pad_s;
  logic             r_s;
  logic             rvld_s;
  logic             zn_base_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic             zn_nxt_s;
  logic             vld_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Zero-pad the data to a full 4-ary tree; zeros are neutral for OR.
  always_comb begin
    a_pad_s            = '0;
    a_pad_s[WIDTH-1:0] = A;
  end

  if (LEVELS == 1) begin : g_flat
    assign r_s    = |a_pad_s;
    assign rvld_s = VLD_I;
  end else begin : g_tree
    logic [PAD-1:0]    lvl_d_s [0:LEVELS-2];
    logic [PAD-1:0]    lvl_q_r [0:LEVELS-2];
    logic [LEVELS-2:0] lvl_v_r;

    // Next value for each registered tree level.
    always_comb begin
      lvl_d_s[0] = group_or(a_pad_s);
      for (int j = 1; j <= LEVELS - 2; j++) begin
        lvl_d_s[j] = group_or(lvl_q_r[j-1]);
      end
    end

    // Tree level registers with their valid bits; they hold while EN=0.
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int j = 0; j <= LEVELS - 2; j++) begin
          lvl_q_r[j] <= '0;
        end
        lvl_v_r <= '0;
      end else if (EN) begin
        lvl_q_r[0] <= lvl_d_s[0];
        lvl_v_r[0] <= VLD_I;
        for (int j = 1; j <= LEVELS - 2; j++) begin
          lvl_q_r[j] <= lvl_d_s[j];
          lvl_v_r[j] <= lvl_v_r[j-1];
        end
      end
    end

    // The last level holds four live bits; their OR is the final result.
    assign r_s    = |lvl_q_r[LEVELS-2];
    assign rvld_s = lvl_v_r[LEVELS-2];
  end

  // Result stage next state: clear first, then fold in a valid result.
  always_comb begin
    zn_base_s  = CLR ? 1'b1 : ZN;
    cnt_base_s = CLR ? '0 : CNT;
    zn_nxt_s   = zn_base_s;
    cnt_nxt_s  = cnt_base_s;
    vld_nxt_s  = VLD_O;
    if (EN) begin
      vld_nxt_s = rvld_s;
      if (rvld_s) begin
        if (MODE) begin
          zn_nxt_s = zn_base_s & ~r_s;
        end else begin
          zn_nxt_s = ~r_s;
        end
        if (r_s && (cnt_base_s != CNT_MAX)) begin
          cnt_nxt_s = cnt_base_s + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_base_s;
        end
      end else begin
        zn_nxt_s  = zn_base_s;
        cnt_nxt_s = cnt_base_s;
      end
    end else begin
      vld_nxt_s = VLD_O;
    end
  end

  // Registered outputs; CLR is honoured even while EN=0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ZN    <= 1'b1;
      VLD_O <= 1'b0;
      CNT   <= '0;
    end else begin
      ZN    <= zn_nxt_s;
      VLD_O <= vld_nxt_s;
      CNT   <= cnt_nxt_s;
    end
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__nor_tree_pipe.md
Name: gf180mcu_fd_sc_mcu7t5v0__nor_tree_pipe

Overview:
Parametrised, pipelined wide-NOR reduction. It generalises the fixed 4-input NOR cell to WIDTH inputs by building a tree of 4-input OR groups, with a register after each level. It adds valid tracking, a clock enable, a sticky (latched) mode, and a saturating hit counter. It is used as a registered wide zero-detect or any-flag-low detector in MCU datapaths.

Parameters:
WIDTH, 16, number of data inputs (2..256)
CNT_W, 8, hit-counter width (1..16)
LEVELS, derived as ceil(log4(WIDTH)) with a minimum of 1; not user-overridable; equals the pipeline latency

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  clock enable; 0 = all pipeline and output state holds
VLD_I  input  1  A is valid this cycle
A  input  WIDTH  data inputs; A[0] corresponds to the cell's A1
MODE  input  1  0 = plain NOR, 1 = sticky NOR
CLR  input  1  clears the sticky state and CNT
ZN  output  1  NOR result, registered
VLD_O  output  1  ZN/CNT updated from a valid sample this cycle
CNT  output  CNT_W  saturating count of valid samples whose OR = 1

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. RST has priority over EN, CLR and all data.
- Reset values: ZN=1, VLD_O=0, CNT=0. All pipeline data and valid registers are 0.
- Tree structure:
  - A is zero-padded to 4^LEVELS bits. Padding bits are 0, which is neutral for OR.
  - Level k ORs groups of 4 bits from level k-1 and registers the result alongside a valid bit.
  - The implementation may use alternating NOR/NAND internally. The observable function is fixed.
- Latency: a sample taken with EN=1 and VLD_I=1 at edge t produces VLD_O=1 and the updated ZN/CNT after edge t+LEVELS-1, i.e. visible in cycle t+LEVELS-1. Counted in EN=1 edges: exactly LEVELS EN=1 edges from the capture edge, inclusive.
- Throughput: one sample per EN=1 cycle. There is no backpressure. VLD_I=0 pushes a bubble, with valid=0 and data don't-care.
- EN=0: every register holds, including VLD_O, ZN and CNT. VLD_I and A are ignored that cycle.
- Result stage, on an edge where the final level's valid is 1 (call its OR result R):
  - MODE=0: ZN <= ~R.
  - MODE=1: ZN <= ZN & ~R. Once low, ZN stays low until CLR or RST.
  - CNT <= CNT+1 if R=1 and CNT is not at all-ones. It saturates at 2^CNT_W-1 and never wraps.
- With no valid result on the edge: ZN and CNT hold, and VLD_O <= 0.
- CLR:
  - Acts on any edge, even when EN=0.
  - Sets the sticky state: ZN <= 1, CNT <= 0.
  - If CLR coincides with a valid result with EN=1, the clear applies first and then the result: ZN = ~R, CNT = R ? 1 : 0.
  - CLR does not flush the pipeline. VLD_O still follows valid.
- MODE changes take effect on the next result edge. Switching 1->0 makes the next valid result overwrite ZN; there is no implicit clear.
- RST mid-stream: all in-flight samples are discarded. The first VLD_O after reset comes only from samples captured after RST deasserts.
- Combinational paths: none from inputs to outputs. All outputs are flops.

Test Plan:
1. Reset: RST=1 for 2 cycles with A=16'hFFFF, VLD_I=1 -> ZN=1, VLD_O=0, CNT=0 throughout. After release, A=0 captured at edge t -> VLD_O=1 and ZN=1 at t+1 (WIDTH=16, LEVELS=2).
2. MODE=0 streaming:
   - A sequence 16'h0000, 16'h8000, 16'h0001, 16'h0000, each with VLD_I=1 -> ZN = 1,0,0,1 with a 2-cycle lag, VLD_O high for 4 consecutive cycles, CNT=2.
   - Exercise every single-bit position and the WIDTH=5 and WIDTH=17 padding configurations.
3. Sticky mode: MODE=1 with samples 0, 16'h0010, 0, 0 -> ZN goes 1 then 0 and stays 0. Then CLR=1 for one cycle -> ZN=1, CNT=0. Next zero sample -> ZN=1.
4. Simultaneous CLR and hit:
   - CLR asserted on the same edge that a result with R=1 arrives, CNT=5 beforehand -> ZN=0, CNT=1.
   - Same with R=0 -> ZN=1, CNT=0.
5. EN stall and bubbles: interleave VLD_I=0 and EN=0 cycles within a 6-sample stream -> outputs identical to the stall-free stream once EN=0 cycles are removed, with no duplicated or lost VLD_O pulses.
6. Saturation and reset mid-flight:
   - CNT_W=2 with 5 hit samples -> CNT = 1,2,3,3,3.
   - Assert RST while 2 samples are in flight -> no VLD_O from them after reset, and CNT=0.
